// File: rtl/addsub_pipe_if.sv
// Operand/result handshake bundle for addsub_pipe: valid/ready on the operand side
// and on the result side, with the arithmetic flags riding alongside the result.
interface addsub_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [1:0]       op;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, op, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, op, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_pipe.sv
// Segmented-carry pipelined adder/subtractor: SEG bits per stage, WIDTH/SEG stages.
// Define ADDSUB_PIPE_FLAGS_EN to compute ovf/zero; otherwise both are tied to 0.
module addsub_pipe #(
  parameter int WIDTH = 8,
  parameter int SEG   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  addsub_pipe_if.slave bus
);
  localparam int NS = WIDTH / SEG;

  logic stall;

  // op[0] selects subtraction; op[1] selects the external carry/borrow.
  function automatic logic eff_carry(input logic [1:0] sel, input logic c);
    return sel[1] ? (c ^ sel[0]) : sel[0];
  endfunction

  genvar k;
  generate
    for (k = 0; k < NS; k++) begin : stg
      localparam int LO   = k * SEG;
      localparam int HI_W = WIDTH - LO;

      logic              in_vld;
      logic [HI_W-1:0]   in_a;
      logic [HI_W-1:0]   in_b;
      logic              in_c;
      logic [SEG:0]      seg_sum;
      logic [LO+SEG-1:0] nxt_s;
      logic              vld_pk;
      logic              c_pk;
      logic [LO+SEG-1:0] s_pk;

      // stage input: operands from the bus (k=0) or the previous stage registers
      if (k == 0) begin : g_in
        assign in_vld = bus.in_valid;
        assign in_a   = bus.a;
        assign in_b   = bus.op[0] ? ~bus.b : bus.b;
        assign in_c   = eff_carry(bus.op, bus.cin);
        assign nxt_s  = seg_sum[SEG-1:0];
      end else begin : g_in
        assign in_vld = stg[k-1].vld_pk;
        assign in_a   = stg[k-1].g_fwd.a_pk;
        assign in_b   = stg[k-1].g_fwd.b_pk;
        assign in_c   = stg[k-1].c_pk;
        assign nxt_s  = {seg_sum[SEG-1:0], stg[k-1].s_pk};
      end

      assign seg_sum = {1'b0, in_a[SEG-1:0]} + {1'b0, in_b[SEG-1:0]}
                     + {{SEG{1'b0}}, in_c};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pk <= 1'b0;
        end else if (!stall) begin
          vld_pk <= in_vld;
        end
      end

      // stage k -> k+1 boundary: only the not-yet-added operand bits travel on
      if (k < NS - 1) begin : g_fwd
        logic [HI_W-SEG-1:0] a_pk;
        logic [HI_W-SEG-1:0] b_pk;

        always_ff @(posedge clk) begin
          if (!stall) begin
            a_pk <= in_a[HI_W-1:SEG];
            b_pk <= in_b[HI_W-1:SEG];
            c_pk <= seg_sum[SEG];
            s_pk <= nxt_s;
          end
        end
      end else begin : g_out
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            c_pk <= 1'b0;
            s_pk <= '0;
          end else if (!stall) begin
            c_pk <= seg_sum[SEG];
            s_pk <= nxt_s;
          end
        end
      end

`ifdef ADDSUB_PIPE_FLAGS_EN
      // output boundary: flags registered together with the final result slice
      if (k == NS - 1) begin : g_flags
        logic ovf_pk;
        logic zero_pk;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_pk  <= 1'b0;
            zero_pk <= 1'b0;
          end else if (!stall) begin
            ovf_pk  <= (in_a[HI_W-1] == in_b[HI_W-1]) && (seg_sum[SEG-1] != in_a[HI_W-1]);
            zero_pk <= (nxt_s == '0);
          end
        end
      end
`endif
    end
  endgenerate

  assign bus.out_valid = stg[NS-1].vld_pk;
  assign bus.sum       = stg[NS-1].s_pk;
  assign bus.cout      = stg[NS-1].c_pk;
  assign stall         = bus.out_valid && !bus.out_ready;
  assign bus.in_ready  = !stall;

`ifdef ADDSUB_PIPE_FLAGS_EN
  assign bus.ovf  = stg[NS-1].g_flags.ovf_pk;
  assign bus.zero = stg[NS-1].g_flags.zero_pk;
`else
  assign bus.ovf  = 1'b0;
  assign bus.zero = 1'b0;
`endif
endmodule

// File: doc/addsub_pipe.md
ADDSUB_PIPE -- requirements
Module: addsub_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits; SHALL be a multiple of SEG.
REQ-002 Parameter SEG, default 4: carry-chain bits per pipeline stage; number of stages NS = WIDTH/SEG.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  operand set is presented.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  first operand.
REQ-008 b  input  WIDTH  second operand.
REQ-009 op  input  2  operation: 00 ADD, 01 SUB, 10 ADDC, 11 SUBB.
REQ-010 cin  input  1  carry-in for ADDC; borrow-in for SUBB.
REQ-011 out_valid  output  1  result is presented.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 sum  output  WIDTH  result.
REQ-014 cout  output  1  carry-out of the MSB; for SUB/SUBB, 1 = no borrow.
REQ-015 ovf  output  1  two's-complement signed overflow.
REQ-016 zero  output  1  sum equals 0.

Function
REQ-017 Effective operand SHALL be b for ADD/ADDC and bitwise ~b for SUB/SUBB.
REQ-018 Effective carry-in SHALL be 0 for ADD, 1 for SUB, cin for ADDC, ~cin for SUBB.
REQ-019 Result SHALL equal a + b_eff + c_eff, modulo 2^WIDTH, with cout as bit WIDTH.
REQ-020 Stage k (0..NS-1) SHALL add bit slice [k*SEG +: SEG], using the carry registered from stage k-1 (stage 0 uses c_eff); lower result slices and upper operand slices SHALL be carried forward in pipeline registers.
REQ-021 Latency SHALL be exactly NS cycles from input handshake (in_valid && in_ready) to out_valid, absent stalls.
REQ-022 Throughput SHALL be one operation per cycle when out_ready is held high.
REQ-023 Stall condition: stall = out_valid && !out_ready; when stall, every pipeline stage (data and valid) SHALL hold.
REQ-024 in_ready SHALL equal !stall (combinational); an input presented while in_ready=0 SHALL NOT be captured.
REQ-025 Bubbles (in_valid=0 on an accepted cycle) SHALL propagate as invalid stage entries; out_valid SHALL be low for them.
REQ-026 sum, cout, ovf, zero SHALL be stable while out_valid && !out_ready.
REQ-027 ovf SHALL be 1 iff a[MSB] == b_eff[MSB] and sum[MSB] != a[MSB].
REQ-028 Results SHALL leave in acceptance order; no operation SHALL be dropped or duplicated.
REQ-029 NS=1 (SEG=WIDTH) SHALL give one-cycle latency with identical handshake rules.

Reset
REQ-030 On rst_n low, all stage valid bits, sum, cout, ovf, zero SHALL clear to 0 immediately, and out_valid SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; none SHALL appear after rst_n rises.
REQ-032 The first input handshake SHALL be possible on the first rising edge with rst_n high.

Configuration
REQ-033 Macro ADDSUB_PIPE_FLAGS_EN defined: ovf and zero SHALL be computed per REQ-016/REQ-027 and registered with the result.
REQ-034 Macro ADDSUB_PIPE_FLAGS_EN undefined: ovf and zero ports SHALL remain present and be driven constant 0; sum, cout, latency unchanged.

Verification (WIDTH=8, SEG=4, NS=2, flags enabled)
REQ-035 ADD a=0x0F b=0x01, out_ready=1 -> two cycles later sum=0x10 cout=0 ovf=0 zero=0.
REQ-036 SUB a=0x80 b=0x01 -> sum=0x7F cout=1 ovf=1; SUB a=0x05 b=0x05 -> sum=0x00 cout=1 zero=1.
REQ-037 ADDC a=0xFF b=0x00 cin=1 -> sum=0x00 cout=1 zero=1; SUBB a=0x00 b=0x00 cin=1 -> sum=0xFF cout=0.
REQ-038 Back-to-back 4 ADDs with out_ready=0 from the cycle the first result appears for 3 cycles -> in_ready=0 during stall, outputs held, all 4 results delivered in order once out_ready=1.
REQ-039 rst_n pulsed low with 2 operations in flight -> out_valid=0 immediately, no result emerges after release; next ADD 0x01+0x01 yields sum=0x02.
REQ-040 Rebuild without ADDSUB_PIPE_FLAGS_EN, repeat REQ-036 -> sum and cout identical, ovf=0 and zero=0.
